// File: rtl/eth_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// eth_tx_arbiter_pkg
// Shared Ethernet TX definitions. This package holds the arbiter state
// encoding and the default word width and frame length. Users of
// ether_tx_driver pick up the same defaults from here.
// -----------------------------------------------------------------------------
package eth_tx_arbiter_pkg;

    localparam int ETH_DATA_WIDTH_MSB = 15;
    localparam int ETH_MAX_BEATS      = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DROP = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. The search starts at ptr+1 and wraps
// modulo NUM_REQ. It returns the first requesting index.
// Ports:
//   req  - request vector, one bit per source
//   ptr  - index of the previous winner
//   any  - at least one request is present
//   idx  - index of the chosen source (0 when there is no request)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic               any,
    output logic [IDW-1:0]     idx
);

    logic           found;
    logic [IDW-1:0] cand;

    assign any = |req;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// -----------------------------------------------------------------------------
// eth_tx_arbiter
// Selects one of NUM_REQ frame sources round-robin and forwards the granted
// frame to the tx driver word by word. There is no buffering: ready/valid pass
// straight through. A frame longer than MAX_BEATS is cut. The arbiter forces
// last on beat MAX_BEATS, flags trunc_err, and discards the rest of the frame.
// Each frame is followed by IFG_CYCLES idle cycles.
//
// state | meaning
// IDLE  | no owner; pick the next source when any req_valid is high
// XFER  | forwarding the granted source to the tx driver
// DROP  | frame truncated; swallow source words up to its last
// GAP   | inter-frame gap, all handshakes held off
//
// Ports:
//   clk, rst                  - clock, async active-high reset
//   req_data/valid/last/ready - packed per-source word streams
//   tx_drv_wr_*               - single word stream to the tx driver
//   grant_id                  - index of the current/last owner
//   busy                      - high in every state except IDLE
//   trunc_err                 - one-cycle pulse when a frame is truncated
// -----------------------------------------------------------------------------
module eth_tx_arbiter
    import eth_tx_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH_MSB = ETH_DATA_WIDTH_MSB,
    parameter int NUM_REQ        = 4,
    parameter int MAX_BEATS      = ETH_MAX_BEATS,
    parameter int IFG_CYCLES     = 12
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ*(DATA_WIDTH_MSB+1)-1:0] req_data,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0]                    req_last,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic [DATA_WIDTH_MSB:0]               tx_drv_wr_data,
    output logic                                  tx_drv_wr_valid,
    output logic                                  tx_drv_wr_last,
    input  logic                                  tx_drv_wr_ready,
    output logic [$clog2(NUM_REQ)-1:0]            grant_id,
    output logic                                  busy,
    output logic                                  trunc_err
);

    localparam int W   = DATA_WIDTH_MSB + 1;
    localparam int IDW = $clog2(NUM_REQ);
    localparam int BW  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int GW  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BEATS - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    // When there is no gap, a finished frame goes straight back to IDLE.
    localparam arb_state_t    ST_END    = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;

    arb_state_t     state, nxt;
    logic [IDW-1:0] rr_ptr;
    logic [BW-1:0]  beat_cnt;
    logic [GW-1:0]  gap_cnt;
    logic           pick_any;
    logic [IDW-1:0] pick_idx;
    logic           trunc_set;
    logic           src_valid;
    logic           src_last;
    logic           at_limit;
    logic [W-1:0]   src_words [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign src_words[i] = req_data[i*W +: W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign src_valid = req_valid[grant_id];
    assign src_last  = req_last[grant_id];
    assign at_limit  = (beat_cnt == BEAT_LAST);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt             = state;
        req_ready       = '0;
        tx_drv_wr_data  = '0;
        tx_drv_wr_valid = 1'b0;
        tx_drv_wr_last  = 1'b0;
        trunc_set       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) nxt = ST_XFER;
            end
            ST_XFER: begin
                tx_drv_wr_data      = src_words[grant_id];
                tx_drv_wr_valid     = src_valid;
                tx_drv_wr_last      = src_last || at_limit;
                req_ready[grant_id] = tx_drv_wr_ready;
                if (src_valid && tx_drv_wr_ready) begin
                    if (src_last) begin
                        nxt = ST_END;
                    end else if (at_limit) begin
                        nxt       = ST_DROP;
                        trunc_set = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                req_ready[grant_id] = 1'b1;
                if (src_valid && src_last) nxt = ST_END;
            end
            ST_GAP: begin
                if (gap_cnt == '0) nxt = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= IDW'(NUM_REQ - 1);
            grant_id  <= '0;
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            trunc_err <= 1'b0;
        end else begin
            trunc_err <= trunc_set;
            if (state == ST_IDLE && pick_any) begin
                grant_id <= pick_idx;
                rr_ptr   <= pick_idx;
                beat_cnt <= '0;
            end else if (state == ST_XFER && src_valid && tx_drv_wr_ready) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            // The gap timer counts down and ends the gap at terminal count 0.
            if (nxt == ST_GAP && state != ST_GAP) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == ST_GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule
